layer_generator: RTL and testbench
==================================

Name: layer_generator

Overview:
- Producer side of the layer interface consumed by the block-field module.
- Generates 7-column rows: `layer_map` (block present) and `block_type` (1 = safe, 0 = hazard).
- At game start it issues the initial layers with `load_layer` pulses, then presents a fresh layer for every jump.
- Uses a free-running 16-bit LFSR and guarantees a reachable chain of safe blocks, so the game is never unwinnable.

Parameters:
- SEED, 16'hACE1, LFSR reset value; must be non-zero.
- NUM_INIT_LAYERS, 5, number of `load_layer` pulses issued at game start.
- INIT_GAP, 4, cycles between consecutive init pulses (pulse to pulse), ≥2.
- PATH_START, 3, column (0..6) of the safe path before the first generated layer.
- WARMUP_LAYERS, 8, hazard-free layers after init (only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- module_en  in  1  game running; low holds the block idle.
- jump_left  in  1  one-cycle jump pulse.
- jump_right  in  1  one-cycle jump pulse.
- layer_map_out  out  [0:6]  bit c = 1: block present in column c (bit 0 = leftmost).
- block_type_out  out  [0:6]  bit c = 1: safe block, 0: hazard; don't-care where map bit = 0.
- load_layer  out  1  one-cycle pulse, layer outputs valid in the same cycle.
- init_done  out  1  high once all init layers are issued, until disable/reset.

Behaviour:
- Reset (rst=1), all values at next edge:
  - `layer_map_out`, `block_type_out`, `load_layer`, `init_done` = 0.
  - lfsr = SEED, path_col = PATH_START, counters = 0, state = IDLE.
- LFSR:
  - Fibonacci, x^16+x^14+x^13+x^11+1; shift left, feedback into bit 0.
  - Advances every cycle that rst=0, regardless of module_en.
  - Reseeded only by rst.
- Layer generation is combinational from the current lfsr and path_col, and registered when a layer is issued:
  - Direction: dir = lfsr[0] (1 = +1, 0 = −1).
  - Clamping: forced +1 at path_col=0, forced −1 at path_col=6.
  - New path column: np = path_col ± 1.
  - Map: map = lfsr[7:1] with bit np forced 1.
  - Type: type = lfsr[14:8] with bit np forced 1.
  - On issue: path_col <= np.
- FSM, IDLE:
  - While module_en=0: outputs 0, path_col = PATH_START, counters cleared.
  - module_en=1 → INIT at next edge.
- FSM, INIT:
  - A layer is issued with `load_layer`=1 on the first INIT cycle and then every INIT_GAP cycles, NUM_INIT_LAYERS times in total.
  - Jumps are ignored.
  - After the last pulse → RUN, with `init_done`=1 from the first RUN cycle.
- FSM, RUN:
  - `layer_map_out`/`block_type_out` hold the next layer continuously; the consumer latches them in the jump cycle.
  - On (jump_left | jump_right), the next layer is registered, visible the cycle after the jump.
  - Both jumps asserted together count as one jump.
  - Back-to-back jump cycles each produce a distinct layer.
  - `load_layer` stays 0 in RUN.
- Any state: module_en=0 → IDLE at next edge.
  - Outputs clear, including mid-INIT; a pending pulse is never issued.
  - `init_done` drops.
- Entering RUN: one extra layer is generated on the INIT→RUN edge, so a valid next layer is present before the first jump.
- Invariant: every issued layer has map=1 and type=1 at a column differing by exactly 1 from the previous layer's path column.

Optional Feature:
LAYER_GEN_WARMUP_EN
- Defined:
  - An 8-bit counter counts layers issued in RUN, saturating at WARMUP_LAYERS.
  - While count < WARMUP_LAYERS, `block_type_out` = 7'b1111111 (no hazards).
  - Counter clears in IDLE.
- Undefined: no counter; hazards are possible from the first layer.

Test Plan:
- Init sequence: rst 1 cycle, then module_en=1 held.
  - → exactly 5 `load_layer` pulses, 4 cycles apart.
  - → `init_done`=1 the cycle after the RUN transition.
  - → each pulse's safe column differs by 1 from the previous; first is 2 or 4.
- Jump handling: in RUN, 20 `jump_right` pulses spaced 10 cycles, plus one cycle with both jumps.
  - → outputs change only the cycle after each jump.
  - → 21 new layers; `load_layer` stays 0.
  - → path invariant holds for all layers.
- Clamp edges: PATH_START=0 → first layer safe bit at column 1. PATH_START=6 → column 5, independent of lfsr[0].
- Mid-init disable: module_en=0 after the 2nd init pulse → next cycle all outputs 0, no further pulses. Re-enable → 5 fresh pulses starting from PATH_START.
- Determinism: SEED=16'hACE1, identical stimulus twice after rst → bit-identical output sequence. `jump_left` during INIT → no output change.
- LAYER_GEN_WARMUP_EN defined: first 8 RUN layers have `block_type_out`=7'h7F, the 9th uses LFSR bits. Undefined: first RUN layer type = lfsr[14:8] with path bit forced.

Source files
------------

// File: rtl/layer_generator.sv
// layer_generator: issues 7-column layers built from a free-running 16-bit LFSR, keeping a reachable safe path.
// Optional macro LAYER_GEN_WARMUP_EN: the first WARMUP_LAYERS run layers carry no hazards.
module layer_generator #(
  parameter logic [15:0] SEED            = 16'hACE1,
  parameter int          NUM_INIT_LAYERS = 5,
  parameter int          INIT_GAP        = 4,
  parameter int          PATH_START      = 3,
  parameter int          WARMUP_LAYERS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       module_en,
  input  logic       jump_left,
  input  logic       jump_right,
  output logic [0:6] layer_map_out,
  output logic [0:6] block_type_out,
  output logic       load_layer,
  output logic       init_done
);

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  localparam logic [2:0] PATH_RST = 3'(PATH_START);
  localparam logic [7:0] GAP_LAST = 8'(INIT_GAP - 1);
  localparam logic [7:0] INIT_CNT = 8'(NUM_INIT_LAYERS);

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [2:0]  path_col;
  logic [2:0]  gen_col;
  logic [7:0]  gap_cnt;
  logic [7:0]  layer_cnt;
  logic        gen_up;
  logic [0:6]  gen_map;
  logic [0:6]  gen_type;
  logic [0:6]  issue_type;
  logic        issue;
  logic        issue_pulse;
  logic        issue_run;
  logic        go_idle;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Candidate layer: step the safe path one column, clamped at the edges.
  always_comb begin
    gen_up = lfsr[0];
    if (path_col == 3'd0)
      gen_up = 1'b1;
    else if (path_col == 3'd6)
      gen_up = 1'b0;
    gen_col           = gen_up ? path_col + 3'd1 : path_col - 3'd1;
    gen_map           = lfsr[7:1];
    gen_map[gen_col]  = 1'b1;
    gen_type          = lfsr[14:8];
    gen_type[gen_col] = 1'b1;
  end

`ifdef LAYER_GEN_WARMUP_EN
  localparam logic [7:0] WARM_MAX = 8'(WARMUP_LAYERS);
  logic [7:0] warm_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= WARM_MAX) ? WARM_MAX : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || go_idle)
      warm_cnt <= '0;
    else if (issue_run)
      warm_cnt <= sat_inc(warm_cnt);
  end

  assign issue_type = (issue_run && (warm_cnt < WARM_MAX)) ? 7'h7F : gen_type;
`else
  logic warmup_unused;
  assign warmup_unused = (WARMUP_LAYERS != 0);
  assign issue_type    = gen_type;
`endif

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    issue_pulse = 1'b0;
    issue_run   = 1'b0;
    go_idle     = 1'b0;
    if (!module_en) begin
      state_nxt = IDLE;
      go_idle   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = INIT;
          issue       = 1'b1;
          issue_pulse = 1'b1;
        end
        INIT: begin
          // The extra layer on the way into RUN pre-loads the first jump target.
          if (layer_cnt == INIT_CNT) begin
            state_nxt = RUN;
            issue     = 1'b1;
            issue_run = 1'b1;
          end else if (gap_cnt == GAP_LAST) begin
            issue       = 1'b1;
            issue_pulse = 1'b1;
          end
        end
        RUN: begin
          if (jump_left || jump_right) begin
            issue     = 1'b1;
            issue_run = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      lfsr           <= SEED;
      path_col       <= PATH_RST;
      gap_cnt        <= '0;
      layer_cnt      <= '0;
      layer_map_out  <= '0;
      block_type_out <= '0;
      load_layer     <= 1'b0;
      init_done      <= 1'b0;
    end else begin
      state      <= state_nxt;
      lfsr       <= lfsr_step(lfsr);
      load_layer <= issue_pulse;
      if (go_idle) begin
        path_col       <= PATH_RST;
        gap_cnt        <= '0;
        layer_cnt      <= '0;
        layer_map_out  <= '0;
        block_type_out <= '0;
        init_done      <= 1'b0;
      end else begin
        if (issue) begin
          layer_map_out  <= gen_map;
          block_type_out <= issue_type;
          path_col       <= gen_col;
        end
        if (issue_pulse) begin
          gap_cnt   <= '0;
          layer_cnt <= layer_cnt + 8'd1;
        end else if (state == INIT) begin
          gap_cnt <= gap_cnt + 8'd1;
        end
        if (issue_run)
          init_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_layer_generator.sv
// Bench for layer_generator: table-driven init/run vectors plus hand sequences for disable, clamp and repeatability.
module tb_layer_generator;

  localparam logic [15:0] SEED     = 16'hACE1;
  localparam logic [2:0]  PS       = 3'd3;
  localparam int          INIT_LEN = 18;
`ifdef LAYER_GEN_WARMUP_EN
  localparam bit WARM = 1'b1;
`else
  localparam bit WARM = 1'b0;
`endif

  typedef struct {
    logic en;
    logic jl;
    logic jr;
    logic iss;
    logic ld;
    logic dn;
  } vec_t;

  typedef struct packed {
    logic [2:0] np;
    logic [0:6] m;
    logic [0:6] t;
  } lay_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       module_en = 1'b0;
  logic       jump_left = 1'b0;
  logic       jump_right = 1'b0;
  logic [0:6] layer_map_out, block_type_out, map0, type0, map6, type6;
  logic       load_layer, init_done, load0, done0, load6, done6;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] lf = SEED;
  logic [15:0] prev = SEED;
  logic [0:6]  e_map = '0;
  logic [0:6]  e_type = '0;
  logic [2:0]  e_path = PS;
  int          e_warm = 0;
  vec_t        tbl[$];
  logic [15:0] rec [0:INIT_LEN-1];

  always #5 clk = ~clk;

  layer_generator dut (
    .clk(clk), .rst(rst), .module_en(module_en), .jump_left(jump_left), .jump_right(jump_right),
    .layer_map_out(layer_map_out), .block_type_out(block_type_out),
    .load_layer(load_layer), .init_done(init_done)
  );

  layer_generator #(.PATH_START(0)) u_clamp0 (
    .clk(clk), .rst(rst), .module_en(module_en), .jump_left(jump_left), .jump_right(jump_right),
    .layer_map_out(map0), .block_type_out(type0), .load_layer(load0), .init_done(done0)
  );

  layer_generator #(.PATH_START(6)) u_clamp6 (
    .clk(clk), .rst(rst), .module_en(module_en), .jump_left(jump_left), .jump_right(jump_right),
    .layer_map_out(map6), .block_type_out(type6), .load_layer(load6), .init_done(done6)
  );

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic lay_t gen(input logic [15:0] s, input logic [2:0] p);
    lay_t r;
    logic up;
    up = s[0];
    if (p == 3'd0) up = 1'b1;
    else if (p == 3'd6) up = 1'b0;
    r.np = up ? p + 3'd1 : p - 3'd1;
    r.m = s[7:1];
    r.m[r.np] = 1'b1;
    r.t = s[14:8];
    r.t[r.np] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  task automatic add(input logic en, jl, jr, iss, ld, dn);
    tbl.push_back('{en, jl, jr, iss, ld, dn});
  endtask

  task automatic model_issue(input logic run);
    lay_t g;
    g = gen(prev, e_path);
    if (run && WARM && e_warm < 8) begin
      g.t = 7'h7F;
      e_warm++;
    end
    e_map  = g.m;
    e_type = g.t;
    e_path = g.np;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    module_en = 1'b0;
    jump_left = 1'b0;
    jump_right = 1'b0;
    @(posedge clk);
    lf = SEED;
    #1;
    e_map = '0;
    e_type = '0;
    e_path = PS;
    e_warm = 0;
    chk("rst_map", 16'(layer_map_out), 16'h0);
    chk("rst_type", 16'(block_type_out), 16'h0);
    chk("rst_load", 16'(load_layer), 16'h0);
    chk("rst_done", 16'(init_done), 16'h0);
    rst = 1'b0;
  endtask

  task automatic cyc(input logic en, jl, jr, iss, ld, dn);
    module_en = en;
    jump_left = jl;
    jump_right = jr;
    prev = lf;
    @(posedge clk);
    lf = rst ? SEED : lfsr_adv(lf);
    #1;
    if (!en) begin
      e_map = '0;
      e_type = '0;
      e_path = PS;
      e_warm = 0;
    end else if (iss) begin
      model_issue(!ld);
      chk("safe_path", {14'h0, layer_map_out[e_path], block_type_out[e_path]}, 16'h3);
    end
    chk("map", 16'(layer_map_out), 16'(e_map));
    chk("type", 16'(block_type_out), 16'(e_type));
    chk("load", 16'(load_layer), 16'(ld));
    chk("done", 16'(init_done), 16'(dn));
  endtask

  task automatic apply_row(input int i, input int mode);
    cyc(tbl[i].en, tbl[i].jl, tbl[i].jr, tbl[i].iss, tbl[i].ld, tbl[i].dn);
    if (mode == 1) rec[i] = {layer_map_out, block_type_out, load_layer, init_done};
    else if (mode == 2) chk("repeat", {layer_map_out, block_type_out, load_layer, init_done}, rec[i]);
  endtask

  initial begin
    // en jl jr iss ld dn ; rows 0..17 = init sequence, 18..25 = first run cycles
    add(1,0,0, 1,1,0); add(1,0,0, 0,0,0); add(1,1,0, 0,0,0); add(1,0,1, 0,0,0);
    add(1,0,0, 1,1,0); add(1,0,0, 0,0,0); add(1,1,1, 0,0,0); add(1,0,0, 0,0,0);
    add(1,0,0, 1,1,0); add(1,1,0, 0,0,0); add(1,0,0, 0,0,0); add(1,0,0, 0,0,0);
    add(1,0,0, 1,1,0); add(1,0,0, 0,0,0); add(1,0,0, 0,0,0); add(1,0,1, 0,0,0);
    add(1,0,0, 1,1,0); add(1,0,0, 1,0,1);
    add(1,0,0, 0,0,1); add(1,1,0, 1,0,1); add(1,0,0, 0,0,1); add(1,0,1, 1,0,1);
    add(1,1,1, 1,0,1); add(1,1,0, 1,0,1); add(1,0,0, 0,0,1); add(1,0,0, 0,0,1);

    do_reset();
    for (int i = 0; i < INIT_LEN; i++) begin
      apply_row(i, 1);
      if (i == 0) begin
        chk("first_col", {13'h0, e_path}, {13'h0, (SEED[0] ? PS + 3'd1 : PS - 3'd1)});
        chk("clamp0_map", 16'(map0), 16'(gen(prev, 3'd0).m));
        chk("clamp0_type", 16'(type0), 16'(gen(prev, 3'd0).t));
        chk("clamp0_safe1", {14'h0, map0[1], type0[1]}, 16'h3);
        chk("clamp6_map", 16'(map6), 16'(gen(prev, 3'd6).m));
        chk("clamp6_type", 16'(type6), 16'(gen(prev, 3'd6).t));
        chk("clamp6_safe5", {14'h0, map6[5], type6[5]}, 16'h3);
        chk("clamp_ctl", {12'h0, load0, done0, load6, done6}, 16'b1010);
      end
    end
    for (int i = INIT_LEN; i < tbl.size(); i++) apply_row(i, 0);

    for (int k = 0; k < 20; k++) begin
      cyc(1, 0, 1, 1, 0, 1);
      for (int j = 0; j < 9; j++) cyc(1, 0, 0, 0, 0, 1);
    end

    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) apply_row(i, 0);
    for (int j = 0; j < 8; j++) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < INIT_LEN; i++) apply_row(i, 0);

    do_reset();
    for (int i = 0; i < INIT_LEN; i++) apply_row(i, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
